// File: rtl/rios_fifo_pkg.sv
// rios_fifo_pkg: shared state encoding for FIFO pop/skid stages
package rios_fifo_pkg;
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pop_state_e;
endpackage

// File: rtl/fifo_pop_stage.sv
// fifo_pop_stage: two-entry main/skid stage draining an upstream FIFO; FIFO_POP_STAGE_FLUSH_EN adds a flush input
module fifo_pop_stage
   import rios_fifo_pkg::*;
#(
   parameter int FIFO_DATA_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       reset,
`ifdef FIFO_POP_STAGE_FLUSH_EN
   input  logic                       flush,
`endif
   input  logic                       fifo_empty,
   input  logic [FIFO_DATA_WIDTH-1:0] fifo_rdata,
   output logic                       fifo_rd_en,
   output logic                       out_valid,
   output logic [FIFO_DATA_WIDTH-1:0] out_data,
   input  logic                       out_ready,
   output logic [1:0]                 occ
);
   pop_state_e                 state_q, state_d;
   logic [FIFO_DATA_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic                       flush_w, pop;

`ifdef FIFO_POP_STAGE_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // Pop request never looks at out_ready, so upstream timing is register-bound; reset gates it off immediately
   assign fifo_rd_en = reset & ~fifo_empty & (state_q != TWO) & ~flush_w;
   assign out_valid  = (state_q != EMPTY);
   assign out_data   = main_q;
   assign occ        = state_q;
   assign pop        = out_valid & out_ready;

   // Next state and slot updates: main always holds the oldest entry, skid the newer one
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (fifo_rd_en) begin
               state_d = ONE;
               main_d  = fifo_rdata;
            end
         end
         ONE: begin
            if (fifo_rd_en && pop) begin
               main_d = fifo_rdata;
            end else if (fifo_rd_en) begin
               state_d = TWO;
               skid_d  = fifo_rdata;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush_w) state_d = EMPTY;
   end

   // State and slot registers with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end
endmodule

// File: doc/fifo_pop_stage.md
FIFO_POP_STAGE -- requirements
Module: fifo_pop_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter FIFO_DATA_WIDTH, default 5, SHALL set the width of popped entries.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 Port fifo_empty SHALL be an input, 1 bit: upstream FIFO holds no entry.
REQ-006 Port fifo_rdata SHALL be an input, FIFO_DATA_WIDTH bits: upstream FIFO head entry, combinational.
REQ-007 Port fifo_rd_en SHALL be an output, 1 bit: pops the upstream head at this clock edge.
REQ-008 Port out_valid SHALL be an output, 1 bit: out_data holds a valid entry.
REQ-009 Port out_data SHALL be an output, FIFO_DATA_WIDTH bits: the oldest held entry.
REQ-010 Port out_ready SHALL be an input, 1 bit: the consumer accepts out_data this cycle.
REQ-011 Port occ SHALL be an output, 2 bits: number of entries currently held (0..2).

Function
REQ-012 The block SHALL hold two entries: a main slot, which drives out_data, and a skid slot.
REQ-013 States: EMPTY (occ=0), ONE (occ=1), TWO (occ=2); occ SHALL equal the state encoding.
REQ-014 fifo_rd_en SHALL equal !fifo_empty & (state != TWO); it depends on no combinational path from out_ready.
REQ-015 A push SHALL occur when fifo_rd_en=1, capturing fifo_rdata; a pop SHALL occur when out_valid & out_ready.
REQ-016 out_valid SHALL equal (state != EMPTY) and SHALL be driven from registers only.
REQ-017 Latency: data on fifo_rdata in cycle N with fifo_rd_en=1 SHALL appear on out_data in cycle N+1.
REQ-018 Transitions, for the cases push only / pop only / both / neither:
- EMPTY: push -> ONE; otherwise stay.
- ONE: push only -> TWO; pop only -> EMPTY; both or neither -> ONE.
- TWO: pop -> ONE; otherwise stay (no push is possible in TWO).
REQ-019 ONE with push and pop in the same cycle SHALL load the pushed entry into the main slot.
REQ-020 ONE with push only SHALL write the skid slot; TWO with pop SHALL move skid to main.
REQ-021 Order SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-022 With fifo_empty=0 and out_ready held at 1, throughput SHALL be one entry per cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 Asserting reset SHALL asynchronously force state=EMPTY, occ=0, out_valid=0, and fifo_rd_en=0, and SHALL clear both slots to 0.
REQ-026 Reset asserted mid-transfer SHALL discard held entries; the upstream FIFO state is not the responsibility of this block.
REQ-027 Release of reset SHALL be synchronous to clk; the first push SHALL be possible on the first edge after release.

Configuration
REQ-028 Macro FIFO_POP_STAGE_FLUSH_EN, when defined, SHALL add input flush (1 bit).
REQ-029 With the macro defined, flush=1 SHALL force fifo_rd_en=0 in the same cycle and set state=EMPTY at the next edge; flush overrides push and pop.
REQ-030 With the macro undefined, the flush port SHALL not exist and behaviour SHALL be as REQ-012 to REQ-024.

Structure
REQ-031 The state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) SHALL live in the shared package rios_fifo_pkg.
REQ-032 The block SHALL be a single module with no sub-module; it instantiates directly after fifo_tmp-class FIFOs.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset with fifo_empty=0 -> fifo_rd_en=0, out_valid=0, occ=0 while reset=0.
- FIFO supplies 0x03, 0x07, 0x1F; out_ready=1 throughout -> out_data 0x03, 0x07, 0x1F on consecutive cycles, each one cycle after its pop, occ=1.
- out_ready=0; FIFO supplies 0x0A, 0x0B, 0x0C -> exactly two pops, occ=2, out_data=0x0A stable; fifo_rd_en=0 while in TWO.
- From TWO with 0x0A, 0x0B held, raise out_ready for one cycle -> 0x0A accepted, out_data=0x0B, occ=1, fifo_rd_en=1 in the same cycle, 0x0C captured next.
- fifo_empty=1 throughout; toggle out_ready -> fifo_rd_en=0, out_valid=0, no state change.
- FIFO_POP_STAGE_FLUSH_EN defined; occ=2; flush=1 with out_ready=1 -> fifo_rd_en=0 that cycle, occ=0 and out_valid=0 next cycle.
